// File: rtl/ask4_symbol_upsampler.sv
// rtl/ask4_symbol_upsampler.sv - 4-ASK symbol mapper, symbol FIFO and zero-stuffing upsampler
//
// Front end of the pulse-shaping chain. Buffers 2-bit symbols, Gray-maps each one to a
// 4-ASK level in 1s17, and inserts SAM_PER_SYM-1 zero samples after every symbol. It also
// owns the sample/symbol clock enables so the downstream time-shared FIR runs on the same
// time base.
//
// Ports:
//   sys_clk     in   system clock
//   reset       in   synchronous, active-high
//   sym_data    in   [1:0] symbol bits, MSB first
//   sym_valid   in   sym_data is valid
//   sym_ready   out  FIFO can accept a symbol (not full)
//   sam_clk_en  out  one-cycle pulse per sample period (combinational)
//   sym_clk_en  out  one-cycle pulse on symbol-phase samples (combinational)
//   x_out       out  [WIDTH-1:0] signed 1s17 upsampled symbol stream to the FIR
//   fifo_level  out  [2:0] FIFO occupancy, 0..FIFO_DEPTH
//   underflow   out  sticky: a symbol phase found the FIFO empty
module ask4_symbol_upsampler #(
  parameter int WIDTH       = 18,
  parameter int SYS_PER_SAM = 4,
  parameter int SAM_PER_SYM = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int LVL_OUTER   = 98304,
  parameter int LVL_INNER   = 32768
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic [1:0]       sym_data,
  input  logic             sym_valid,
  output logic             sym_ready,
  output logic             sam_clk_en,
  output logic             sym_clk_en,
  output logic [WIDTH-1:0] x_out,
  output logic [2:0]       fifo_level,
  output logic             underflow
);

  localparam int SAM_W = (SYS_PER_SAM > 1) ? $clog2(SYS_PER_SAM) : 1;
  localparam int SYM_W = (SAM_PER_SYM > 1) ? $clog2(SAM_PER_SYM) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [SAM_W-1:0] SAM_LAST = SAM_W'(SYS_PER_SAM - 1);
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SAM_PER_SYM - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  localparam logic [WIDTH-1:0] OUTER_POS = WIDTH'(LVL_OUTER);
  localparam logic [WIDTH-1:0] OUTER_NEG = WIDTH'(-LVL_OUTER);
  localparam logic [WIDTH-1:0] INNER_POS = WIDTH'(LVL_INNER);
  localparam logic [WIDTH-1:0] INNER_NEG = WIDTH'(-LVL_INNER);

  logic [SAM_W-1:0] sam_cnt;
  logic [SYM_W-1:0] sym_cnt;

  logic [1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_level;

  // Both enables are gated by reset so a reset landing on the last sub-cycle
  // cannot leak a pulse to the filter.
  assign sam_clk_en = (sam_cnt == SAM_LAST) && !reset;
  assign sym_clk_en = sam_clk_en && (sym_cnt == '0);

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_FULL);
  assign sym_ready  = !fifo_full;
  assign fifo_level = 3'(count);

  // Occupancy is registered, so a symbol arriving on the same edge as a pop on an
  // empty FIFO is never bypassed to the output; it waits for the next symbol phase.
  assign push = sym_valid && !fifo_full;
  assign pop  = sym_clk_en && !fifo_empty;

  // Gray mapping: adjacent levels differ in one bit.
  always_comb begin
    head_level = '0;
    case (mem[rd_ptr])
      2'b00:   head_level = OUTER_NEG;
      2'b01:   head_level = INNER_NEG;
      2'b11:   head_level = INNER_POS;
      default: head_level = OUTER_POS;
    endcase
  end

  // Symbol storage carries no reset; occupancy and pointers define what is valid.
  always_ff @(posedge sys_clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= sym_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      sam_cnt   <= '0;
      sym_cnt   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      x_out     <= '0;
      underflow <= 1'b0;
    end else begin
      sam_cnt <= (sam_cnt == SAM_LAST) ? '0 : sam_cnt + SAM_W'(1);

      if (sam_clk_en) begin
        sym_cnt <= (sym_cnt == SYM_LAST) ? '0 : sym_cnt + SYM_W'(1);
        if (sym_cnt == '0) begin
          if (!fifo_empty) begin
            x_out <= head_level;
          end else begin
            x_out     <= '0;
            underflow <= 1'b1;
          end
        end else begin
          x_out <= '0;
        end
      end

      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ask4_symbol_upsampler.sv
// tb/tb_ask4_symbol_upsampler.sv - scoreboard bench for ask4_symbol_upsampler
//
// The reference model tracks time in sys_clk cycles since reset release: sample
// edges fall on t%4==3, symbol phases on t%16==3. The symbol FIFO is a plain queue.
// Expected x_out values are queued at each sample edge and consumed by an
// independent monitor.
module tb_ask4_symbol_upsampler;

  logic              sys_clk = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        sym_data = 2'b00;
  logic              sym_valid = 1'b0;
  logic              sym_ready;
  logic              sam_clk_en;
  logic              sym_clk_en;
  logic signed [17:0] x_out;
  logic [2:0]        fifo_level;
  logic              underflow;

  int checks = 0;
  int errors = 0;

  int sb[$];
  int mq[$];
  int t = 0;
  bit m_uf = 1'b0;

  int cur_exp = 0;
  bit prev_en = 1'b0;

  ask4_symbol_upsampler dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .sym_data   (sym_data),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .sam_clk_en (sam_clk_en),
    .sym_clk_en (sym_clk_en),
    .x_out      (x_out),
    .fifo_level (fifo_level),
    .underflow  (underflow)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic int level(int s);
    int lv[4];
    lv = '{-98304, -32768, 98304, 32768};
    return lv[s];
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", name, act, exp, t, $time);
    end
  endtask

  // One sys_clk cycle: check visible state, drive inputs, advance the model.
  task automatic step(bit v, logic [1:0] d);
    bit ready_pre;
    chk("sam_clk_en", int'(sam_clk_en), int'(t % 4 == 3));
    chk("sym_clk_en", int'(sym_clk_en), int'(t % 16 == 3));
    chk("fifo_level", int'(fifo_level), mq.size());
    chk("sym_ready", int'(sym_ready), int'(mq.size() < 4));
    chk("underflow", int'(underflow), int'(m_uf));
    sym_valid = v;
    sym_data  = d;
    ready_pre = (mq.size() < 4);
    if (t % 4 == 3) begin
      if (t % 16 == 3) begin
        if (mq.size() > 0) begin
          sb.push_back(level(mq.pop_front()));
        end else begin
          sb.push_back(0);
          m_uf = 1'b1;
        end
      end else begin
        sb.push_back(0);
      end
    end
    if (v && ready_pre) mq.push_back(int'(d));
    t++;
    @(negedge sys_clk);
    #1;
  endtask

  task automatic do_reset(int n);
    reset     = 1'b1;
    sym_valid = 1'($urandom_range(0, 1));
    sym_data  = 2'($urandom);
    #1;
    chk("sam_clk_en_gated", int'(sam_clk_en), 0);
    sb.delete();
    mq.delete();
    m_uf = 1'b0;
    repeat (n) begin
      @(negedge sys_clk);
      #1;
      chk("rst_fifo_level", int'(fifo_level), 0);
      chk("rst_sym_ready", int'(sym_ready), 1);
      chk("rst_x_out", int'(x_out), 0);
      chk("rst_underflow", int'(underflow), 0);
      chk("rst_sam_clk_en", int'(sam_clk_en), 0);
      chk("rst_sym_clk_en", int'(sym_clk_en), 0);
    end
    reset     = 1'b0;
    sym_valid = 1'b0;
    t         = 0;
  endtask

  always @(negedge sys_clk) begin
    if (reset) begin
      cur_exp = 0;
      prev_en = 1'b0;
    end else begin
      if (prev_en) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underrun: sample edge with no expected value (time %0t)", $time);
        end else begin
          cur_exp = sb.pop_front();
        end
      end
      checks++;
      if (int'(x_out) != cur_exp) begin
        errors++;
        $display("FAIL x_out: got %0d expected %0d (time %0t)", x_out, cur_exp, $time);
      end
      prev_en = sam_clk_en;
    end
  end

  initial begin
    @(negedge sys_clk);
    #1;
    do_reset(2);

    // Idle after reset: enables tick, x_out stays 0, underflow at first symbol phase.
    repeat (40) step(1'b0, 2'b00);

    // Four symbols loaded ahead of the first symbol phase.
    do_reset(1);
    step(1'b1, 2'b00);
    step(1'b1, 2'b01);
    step(1'b1, 2'b11);
    step(1'b1, 2'b10);
    repeat (70) step(1'b0, 2'b00);

    // Continuous valid: FIFO fills and back-pressures.
    do_reset(1);
    repeat (120) step(1'b1, 2'($urandom));

    // Push on the same edge as a symbol-phase pop on an empty FIFO.
    do_reset(1);
    repeat (3) step(1'b0, 2'b00);
    step(1'b1, 2'b10);
    repeat (40) step(1'b0, 2'b00);

    // Reset mid-symbol with three symbols queued.
    do_reset(1);
    repeat (4) step(1'b1, 2'($urandom));
    repeat (5) step(1'b0, 2'b00);
    do_reset(1);
    repeat (20) step(1'b0, 2'b00);

    // Randomized traffic with occasional resets at arbitrary phases.
    repeat (30) begin
      int p;
      p = $urandom_range(3, 40);
      repeat ($urandom_range(20, 200)) step(1'($urandom_range(0, 99) < p), 2'($urandom));
      if ($urandom_range(0, 3) == 0) do_reset($urandom_range(1, 3));
    end

    step(1'b0, 2'b00);
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
